fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
Shares the single pixel-buffer write port behind the VGA scan-out between two pixel producers. Requester A is the Nios Avalon pixel port and requester B is the line-drawing engine. Arbitration is round-robin; each accepted pixel is range-checked, converted from (x,y) to a linear address and registered onto the buffer write port. A built-in clear sequencer fills the whole frame with one colour on command and locks out both requesters while it runs.

Parameters:
H_RES, 320, visible pixels per line
V_RES, 240, visible lines per frame
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
COLOR_W, 24, pixel colour width (8R/8G/8B)
ADDR_W, 17, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
a_valid  in  1  requester A has a pixel
a_ready  out  1  A pixel accepted this cycle
a_x  in  X_W  A x coordinate
a_y  in  Y_W  A y coordinate
a_color  in  COLOR_W  A colour
b_valid  in  1  requester B has a pixel
b_ready  out  1  B pixel accepted this cycle
b_x  in  X_W  B x coordinate
b_y  in  Y_W  B y coordinate
b_color  in  COLOR_W  B colour
clear_start  in  1  one-cycle pulse: begin frame clear
clear_color  in  COLOR_W  fill colour, sampled with clear_start
clear_busy  out  1  clear in progress
clear_done  out  1  one-cycle pulse when clear finishes
fb_we  out  1  write strobe to pixel buffer
fb_addr  out  ADDR_W  write address, y*H_RES+x
fb_wdata  out  COLOR_W  write data
fb_waitrequest  in  1  buffer stall; the write is held while high
drop_count  out  16  count of out-of-range pixels, saturates at 0xFFFF

Behaviour:
- clk and reset_n: one clock domain; reset is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; round-robin pointer favours A; drop_count 0.
- Output register (fb_we/fb_addr/fb_wdata) holds one write.
  - It is free when fb_we=0, or when fb_we=1 and fb_waitrequest=0.
  - While fb_we=1 and fb_waitrequest=1, addr and data hold stable and nothing new is accepted.
- States:
  - IDLE: arbitration is active.
  - CLEAR: sequencer owns the port.
  - CLEAR_DRAIN: waits for the final clear write to complete.
- Arbitration (IDLE, output register free):
  - If exactly one valid, grant it.
  - If both valid, grant the requester not granted last; the pointer updates only on a grant.
  - x_ready is combinational and high for exactly the grant cycle.
  - Pixels are held by the requester until ready is seen.
- Latency: pixel accepted in cycle N -> fb_we=1 with its addr and data in cycle N+1.
- Range check:
  - Pixels with x>=H_RES or y>=V_RES are accepted (ready=1) but not written; fb_we is 0 next cycle.
  - drop_count increments by 1, saturating.
  - A dropped grant still advances the pointer.
- Address arithmetic: y*H_RES+x computed at full width, then truncated to ADDR_W. Only in-range values reach the port.
- Clear:
  - clear_start in IDLE latches clear_color and enters CLEAR.
  - Arbitration is suppressed from that cycle on.
  - If both clear_start and a grant are possible in the same cycle, clear wins and no ready is given.
  - A pending write in the output register completes first.
  - CLEAR issues addresses 0..H_RES*V_RES-1 in order, one per free cycle, honouring waitrequest.
  - After the last address is loaded, go to CLEAR_DRAIN.
  - When that write completes: clear_done=1 for one cycle, clear_busy drops, return to IDLE.
  - clear_busy is high throughout CLEAR and CLEAR_DRAIN.
  - clear_start while busy is ignored.
  - a_ready and b_ready are 0 while busy.
- Reset mid-operation: immediate return to reset values. A partially issued write or clear is abandoned, with no clear_done.

Test Plan:
- A: x=10, y=20, color=0xFF0000, B idle -> a_ready in cycle N; cycle N+1 shows fb_we=1, fb_addr=6410, fb_wdata=0xFF0000.
- A and B both continuously valid for 4 grants after reset -> grant order A,B,A,B; ready never high on both sides in one cycle.
- fb_waitrequest held high for 3 cycles during a write, with A valid -> fb_addr and fb_wdata stable for 4 cycles; a_ready low until the cycle the write completes.
- B: x=320, y=5 -> b_ready=1, no fb_we, drop_count=1; 0x10000 bad pixels -> drop_count stays 0xFFFF.
- clear_start with clear_color=0x0000FF, A valid throughout -> 76800 writes to addresses 0..76799 with data 0x0000FF.
  - clear_busy is high throughout; a_ready stays 0.
  - clear_done pulses once.
  - A is granted on the next free cycle after the clear.
- reset_n low at address 1000 of a clear -> all outputs 0 asynchronously; after release the block is IDLE, clear_done never pulsed, and a new clear restarts at address 0.

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// Pixel-buffer write arbiter bus bundle.
// Groups both requester handshakes, the clear-sequencer controls, the
// pixel-buffer write port and the drop counter.
//   slave  : arbiter side (fb_write_arbiter)
//   master : environment side (requesters, buffer, controller)
// Widths must match the parameters of the fb_write_arbiter instance.
interface fb_write_arbiter_if #(
   parameter int unsigned X_W     = 9,
   parameter int unsigned Y_W     = 8,
   parameter int unsigned COLOR_W = 24,
   parameter int unsigned ADDR_W  = 17
) ();
   // requester A (Nios Avalon pixel port)
   logic               a_valid;
   logic               a_ready;
   logic [X_W-1:0]     a_x;
   logic [Y_W-1:0]     a_y;
   logic [COLOR_W-1:0] a_color;
   // requester B (line-drawing engine)
   logic               b_valid;
   logic               b_ready;
   logic [X_W-1:0]     b_x;
   logic [Y_W-1:0]     b_y;
   logic [COLOR_W-1:0] b_color;
   // frame clear control
   logic               clear_start;
   logic [COLOR_W-1:0] clear_color;
   logic               clear_busy;
   logic               clear_done;
   // pixel-buffer write port
   logic               fb_we;
   logic [ADDR_W-1:0]  fb_addr;
   logic [COLOR_W-1:0] fb_wdata;
   logic               fb_waitrequest;
   // status
   logic [15:0]        drop_count;

   modport slave (
      input  a_valid, a_x, a_y, a_color,
      input  b_valid, b_x, b_y, b_color,
      input  clear_start, clear_color,
      input  fb_waitrequest,
      output a_ready, b_ready,
      output clear_busy, clear_done,
      output fb_we, fb_addr, fb_wdata,
      output drop_count
   );

   modport master (
      output a_valid, a_x, a_y, a_color,
      output b_valid, b_x, b_y, b_color,
      output clear_start, clear_color,
      output fb_waitrequest,
      input  a_ready, b_ready,
      input  clear_busy, clear_done,
      input  fb_we, fb_addr, fb_wdata,
      input  drop_count
   );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the pixel-buffer write port between requester
// A (Nios pixel port) and requester B (line engine). Accepted pixels are
// range-checked, converted to y*H_RES+x and registered onto the write port.
// A clear sequencer fills the whole frame with one colour on command,
// locking out both requesters while it runs.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : fb_write_arbiter_if slave modport (requesters, clear control,
//             buffer write port, drop counter)
module fb_write_arbiter #(
   parameter int unsigned H_RES   = 320,
   parameter int unsigned V_RES   = 240,
   parameter int unsigned X_W     = 9,
   parameter int unsigned Y_W     = 8,
   parameter int unsigned COLOR_W = 24,
   parameter int unsigned ADDR_W  = 17
) (
   input  logic              clk,
   input  logic              reset_n,
   fb_write_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_CLEAR_DRAIN
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

   state_e             state_q;
   logic               prefer_b_q;
   logic [ADDR_W-1:0]  clr_addr_q;
   logic [COLOR_W-1:0] clr_color_q;
   logic               fb_we_q;
   logic [ADDR_W-1:0]  fb_addr_q;
   logic [COLOR_W-1:0] fb_wdata_q;
   logic               busy_q;
   logic               done_q;
   logic [15:0]        drop_q;

   logic               out_free;
   logic               arb_en;
   logic               grant_a;
   logic               grant_b;
   logic [X_W-1:0]     sel_x;
   logic [Y_W-1:0]     sel_y;
   logic [COLOR_W-1:0] sel_color;
   logic               in_range;
   logic [ADDR_W-1:0]  pix_addr_d;

   // Output register can take a new write when empty or when its current
   // write is being accepted this cycle.
   assign out_free = !fb_we_q || !bus.fb_waitrequest;

   // Arbitration only in IDLE with a free output register; clear_start
   // takes precedence. Gated by reset_n so ready stays 0 during reset.
   assign arb_en = reset_n && (state_q == ST_IDLE) && !bus.clear_start && out_free;

   always_comb begin
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      sel_x     = '0;
      sel_y     = '0;
      sel_color = '0;
      if (arb_en) begin
         grant_a = bus.a_valid && (!bus.b_valid || !prefer_b_q);
         grant_b = bus.b_valid && (!bus.a_valid ||  prefer_b_q);
      end
      if (grant_b) begin
         sel_x     = bus.b_x;
         sel_y     = bus.b_y;
         sel_color = bus.b_color;
      end else begin
         sel_x     = bus.a_x;
         sel_y     = bus.a_y;
         sel_color = bus.a_color;
      end
   end

   assign in_range   = (32'(sel_x) < H_RES) && (32'(sel_y) < V_RES);
   // Linear address formed at 32 bits, then truncated to the port width.
   assign pix_addr_d = ADDR_W'(32'(sel_y) * H_RES + 32'(sel_x));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         prefer_b_q  <= 1'b0;
         clr_addr_q  <= '0;
         clr_color_q <= '0;
         fb_we_q     <= 1'b0;
         fb_addr_q   <= '0;
         fb_wdata_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         drop_q      <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.clear_start) begin
                  // A stalled pending write stays in the register; CLEAR
                  // only loads once the register is free.
                  clr_color_q <= bus.clear_color;
                  clr_addr_q  <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_CLEAR;
                  if (out_free) begin
                     fb_we_q <= 1'b0;
                  end
               end else if (out_free) begin
                  fb_we_q <= 1'b0;
                  if (grant_a || grant_b) begin
                     // Pointer advances on every grant, dropped or not.
                     prefer_b_q <= grant_a;
                     if (in_range) begin
                        fb_we_q    <= 1'b1;
                        fb_addr_q  <= pix_addr_d;
                        fb_wdata_q <= sel_color;
                     end else if (drop_q != '1) begin
                        drop_q <= drop_q + 16'd1;
                     end
                  end
               end
            end
            ST_CLEAR: begin
               if (out_free) begin
                  fb_we_q    <= 1'b1;
                  fb_addr_q  <= clr_addr_q;
                  fb_wdata_q <= clr_color_q;
                  if (clr_addr_q == LAST_ADDR) begin
                     state_q <= ST_CLEAR_DRAIN;
                  end else begin
                     clr_addr_q <= clr_addr_q + 1'b1;
                  end
               end
            end
            ST_CLEAR_DRAIN: begin
               if (out_free) begin
                  fb_we_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.a_ready    = grant_a;
   assign bus.b_ready    = grant_b;
   assign bus.fb_we      = fb_we_q;
   assign bus.fb_addr    = fb_addr_q;
   assign bus.fb_wdata   = fb_wdata_q;
   assign bus.clear_busy = busy_q;
   assign bus.clear_done = done_q;
   assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter. The frame is instantiated as
// 320x32 so the full clear stays short; address arithmetic still uses the
// 320-pixel line stride.
module tb_fb_write_arbiter;

   localparam int unsigned H_RES   = 320;
   localparam int unsigned V_RES   = 32;
   localparam int unsigned X_W     = 9;
   localparam int unsigned Y_W     = 8;
   localparam int unsigned COLOR_W = 24;
   localparam int unsigned ADDR_W  = 17;
   localparam int unsigned NPIX    = H_RES * V_RES;

   logic clk;
   logic reset_n;

   fb_write_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)) bus ();

   fb_write_arbiter #(
      .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W),
      .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned vec_cnt = 0;
   int unsigned miss_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        av; logic [8:0] ax; logic [7:0] ay; logic [23:0] ac;
      logic        bv; logic [8:0] bx; logic [7:0] by; logic [23:0] bc;
      logic        wr;
      logic        ea; logic eb; logic ew;
      logic [16:0] eaddr; logic [23:0] edata; logic [15:0] edrop;
   } vec_t;

   vec_t tbl[17];

   task automatic idle_inputs();
      bus.a_valid = 1'b0; bus.a_x = '0; bus.a_y = '0; bus.a_color = '0;
      bus.b_valid = 1'b0; bus.b_x = '0; bus.b_y = '0; bus.b_color = '0;
      bus.clear_start = 1'b0; bus.clear_color = '0; bus.fb_waitrequest = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " fb_we"},      32'(bus.fb_we), 32'd0);
      chk({tag, " fb_addr"},    32'(bus.fb_addr), 32'd0);
      chk({tag, " fb_wdata"},   32'(bus.fb_wdata), 32'd0);
      chk({tag, " clear_busy"}, 32'(bus.clear_busy), 32'd0);
      chk({tag, " clear_done"}, 32'(bus.clear_done), 32'd0);
      chk({tag, " drop_count"}, 32'(bus.drop_count), 32'd0);
      chk({tag, " a_ready"},    32'(bus.a_ready), 32'd0);
      chk({tag, " b_ready"},    32'(bus.b_ready), 32'd0);
   endtask

   initial begin
      int unsigned rdy_miss, wr_cnt, wr_err, busy_err, rdy_err, next_addr, cyc;
      logic done_seen, done_a_ready, done_busy, found;

      //              A: v  x       y      color         B: v  x       y      color         wr    ea    eb    ew    addr       data          drop
      tbl[0]  = '{1'b1, 9'd10,  8'd20, 24'hFF0000, 1'b1, 9'd2,   8'd0, 24'h222222, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0,     24'h0,        16'd0};
      tbl[1]  = '{1'b1, 9'd1,   8'd0,  24'h111111, 1'b1, 9'd2,   8'd0, 24'h222222, 1'b0, 1'b0, 1'b1, 1'b1, 17'd6410,  24'hFF0000,   16'd0};
      tbl[2]  = '{1'b1, 9'd1,   8'd0,  24'h111111, 1'b1, 9'd3,   8'd0, 24'h333333, 1'b0, 1'b1, 1'b0, 1'b1, 17'd2,     24'h222222,   16'd0};
      tbl[3]  = '{1'b1, 9'd4,   8'd0,  24'h444444, 1'b1, 9'd3,   8'd0, 24'h333333, 1'b0, 1'b0, 1'b1, 1'b1, 17'd1,     24'h111111,   16'd0};
      tbl[4]  = '{1'b1, 9'd4,   8'd0,  24'h444444, 1'b0, 9'd0,   8'd0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 17'd3,     24'h333333,   16'd0};
      tbl[5]  = '{1'b1, 9'd319, 8'd31, 24'hABCDEF, 1'b0, 9'd0,   8'd0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 17'd4,     24'h444444,   16'd0};
      tbl[6]  = '{1'b1, 9'd5,   8'd5,  24'h000001, 1'b0, 9'd0,   8'd0, 24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 17'd10239, 24'hABCDEF,   16'd0};
      tbl[7]  = '{1'b1, 9'd5,   8'd5,  24'h000001, 1'b0, 9'd0,   8'd0, 24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 17'd10239, 24'hABCDEF,   16'd0};
      tbl[8]  = '{1'b1, 9'd5,   8'd5,  24'h000001, 1'b0, 9'd0,   8'd0, 24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 17'd10239, 24'hABCDEF,   16'd0};
      tbl[9]  = '{1'b1, 9'd5,   8'd5,  24'h000001, 1'b0, 9'd0,   8'd0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 17'd10239, 24'hABCDEF,   16'd0};
      tbl[10] = '{1'b0, 9'd0,   8'd0,  24'h0,      1'b0, 9'd0,   8'd0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1, 17'd1605,  24'h000001,   16'd0};
      tbl[11] = '{1'b0, 9'd0,   8'd0,  24'h0,      1'b1, 9'd320, 8'd5, 24'h777777, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0,     24'h0,        16'd0};
      tbl[12] = '{1'b0, 9'd0,   8'd0,  24'h0,      1'b0, 9'd0,   8'd0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b0, 17'd0,     24'h0,        16'd1};
      tbl[13] = '{1'b1, 9'd0,   8'd32, 24'h000111, 1'b1, 9'd1,   8'd1, 24'h888888, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0,     24'h0,        16'd1};
      tbl[14] = '{1'b1, 9'd7,   8'd0,  24'h999999, 1'b1, 9'd1,   8'd1, 24'h888888, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0,     24'h0,        16'd2};
      tbl[15] = '{1'b1, 9'd7,   8'd0,  24'h999999, 1'b0, 9'd0,   8'd0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 17'd321,   24'h888888,   16'd2};
      tbl[16] = '{1'b0, 9'd0,   8'd0,  24'h0,      1'b0, 9'd0,   8'd0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1, 17'd7,     24'h999999,   16'd2};

      // Reset state, with A requesting during reset.
      idle_inputs();
      reset_n = 1'b0;
      bus.a_valid = 1'b1;
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      bus.a_valid = 1'b0;
      reset_n = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         bus.a_valid = tbl[i].av; bus.a_x = tbl[i].ax; bus.a_y = tbl[i].ay; bus.a_color = tbl[i].ac;
         bus.b_valid = tbl[i].bv; bus.b_x = tbl[i].bx; bus.b_y = tbl[i].by; bus.b_color = tbl[i].bc;
         bus.fb_waitrequest = tbl[i].wr;
         @(negedge clk);
         chk($sformatf("v%0d a_ready", i), 32'(bus.a_ready), 32'(tbl[i].ea));
         chk($sformatf("v%0d b_ready", i), 32'(bus.b_ready), 32'(tbl[i].eb));
         chk($sformatf("v%0d fb_we", i), 32'(bus.fb_we), 32'(tbl[i].ew));
         if (tbl[i].ew) begin
            chk($sformatf("v%0d fb_addr", i), 32'(bus.fb_addr), 32'(tbl[i].eaddr));
            chk($sformatf("v%0d fb_wdata", i), 32'(bus.fb_wdata), 32'(tbl[i].edata));
         end
         chk($sformatf("v%0d drop_count", i), 32'(bus.drop_count), 32'(tbl[i].edrop));
      end

      // Drop counter saturation: 0x10000 further out-of-range pixels from B.
      @(posedge clk); #1;
      idle_inputs();
      bus.b_valid = 1'b1; bus.b_x = 9'd400; bus.b_y = 8'd0; bus.b_color = 24'h5A5A5A;
      rdy_miss = 0;
      for (int n = 0; n < 32'h10000; n++) begin
         @(negedge clk);
         if (!bus.b_ready || bus.fb_we) rdy_miss++;
         @(posedge clk); #1;
      end
      bus.b_valid = 1'b0;
      @(negedge clk);
      chk("sat b_ready/no write", rdy_miss, 32'd0);
      chk("sat drop_count", 32'(bus.drop_count), 32'hFFFF);
      chk("sat fb_we", 32'(bus.fb_we), 32'd0);

      // Full clear with A requesting throughout and periodic stalls.
      @(posedge clk); #1;
      bus.clear_start = 1'b1; bus.clear_color = 24'h0000FF;
      bus.a_valid = 1'b1; bus.a_x = 9'd6; bus.a_y = 8'd0; bus.a_color = 24'h123456;
      @(negedge clk);
      chk("clear_start a_ready", 32'(bus.a_ready), 32'd0);
      @(posedge clk); #1;
      bus.clear_start = 1'b0;
      wr_cnt = 0; wr_err = 0; busy_err = 0; rdy_err = 0; next_addr = 0; cyc = 0;
      done_seen = 1'b0; done_a_ready = 1'b0; done_busy = 1'b1;
      while (!done_seen && cyc < 3 * NPIX) begin
         bus.fb_waitrequest = (cyc % 5 == 2);
         @(negedge clk);
         if (bus.clear_done) begin
            done_seen = 1'b1;
            done_a_ready = bus.a_ready;
            done_busy = bus.clear_busy;
         end else begin
            if (!bus.clear_busy) busy_err++;
            if (bus.a_ready || bus.b_ready) rdy_err++;
            if (bus.fb_we && !bus.fb_waitrequest) begin
               if (32'(bus.fb_addr) != next_addr || bus.fb_wdata != 24'h0000FF) wr_err++;
               next_addr++;
               wr_cnt++;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.fb_waitrequest = 1'b0;
      bus.a_valid = 1'b0;
      chk("clear_done seen", 32'(done_seen), 32'd1);
      chk("clear write count", wr_cnt, NPIX);
      chk("clear addr/data errors", wr_err, 32'd0);
      chk("clear busy gaps", busy_err, 32'd0);
      chk("clear ready while busy", rdy_err, 32'd0);
      chk("done-cycle a_ready", 32'(done_a_ready), 32'd1);
      chk("done-cycle clear_busy", 32'(done_busy), 32'd0);
      @(negedge clk);
      chk("clear_done single pulse", 32'(bus.clear_done), 32'd0);
      chk("post-clear fb_we", 32'(bus.fb_we), 32'd1);
      chk("post-clear fb_addr", 32'(bus.fb_addr), 32'd6);
      chk("post-clear fb_wdata", 32'(bus.fb_wdata), 32'h123456);

      // Reset asserted at clear address 1000.
      @(posedge clk); #1;
      bus.clear_start = 1'b1; bus.clear_color = 24'h00FF00;
      @(posedge clk); #1;
      bus.clear_start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 2000 && !found; n++) begin
         @(negedge clk);
         if (bus.fb_we && bus.fb_addr == 17'd1000) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("reached clear addr 1000", 32'(found), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk_all_zero("mid-clear reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      busy_err = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (bus.clear_done || bus.clear_busy || bus.fb_we) busy_err++;
      end
      chk("idle after reset, no clear_done", busy_err, 32'd0);
      @(posedge clk); #1;
      bus.clear_start = 1'b1; bus.clear_color = 24'hAA55AA;
      @(posedge clk); #1;
      bus.clear_start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(negedge clk);
         if (bus.fb_we) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("restart clear write seen", 32'(found), 32'd1);
      chk("restart clear fb_addr", 32'(bus.fb_addr), 32'd0);
      chk("restart clear fb_wdata", 32'(bus.fb_wdata), 32'hAA55AA);
      chk("restart clear_busy", 32'(bus.clear_busy), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
